// File: rtl/wb_initiator_if.sv
// Bundle of the request/response handshake ports and the Wishbone classic bus signals
// used by wb_initiator.
//   req_*  : valid/ready request channel (addr, wdata, sel, we) into the initiator
//   resp_* : held response channel (rdata, err, timeout) out of the initiator
//   wb_*   : Wishbone classic initiator-side bus (single outstanding cycle)
// Modport master is the initiator's view; modport slave is the view of whatever surrounds it
// (requester plus Wishbone responder).
interface wb_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        req_we;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;

  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    input  req_valid, req_addr, req_wdata, req_sel, req_we,
    output req_ready,
    output resp_valid, resp_rdata, resp_err, resp_timeout,
    input  resp_ready,
    output wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_rdata, wb_ack, wb_err
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_sel, req_we,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err, resp_timeout,
    output resp_ready,
    input  wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_rdata, wb_ack, wb_err
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator.
// Accepts one request on the valid/ready request channel, runs one single read or write
// bus cycle, and holds the result on the response channel until the consumer takes it.
// A watchdog aborts a bus cycle that is neither acked nor errored within TIMEOUT cycles.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : wb_initiator_if.master (request, response and Wishbone signals)
// Parameters:
//   TIMEOUT : max cycles with cyc/stb high before abort (2..255)
module wb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  wb_initiator_if.master bus
);

  localparam int unsigned WdogW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             req_ready_q, req_ready_d;
  logic             cyc_q, cyc_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          sel_d   = bus.req_sel;
          we_d    = bus.req_we;
          cyc_d   = 1'b1;
          wdog_d  = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        // Saturating so the counter can never wrap back under the timeout threshold.
        if (wdog_q != {WdogW{1'b1}}) begin
          wdog_d = wdog_q + WdogW'(1);
        end
        if (bus.wb_ack) begin
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : bus.wb_rdata;
          state_d = StResp;
        end else if (bus.wb_err) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = 1'b0;
          rdata_d = 32'h0;
          state_d = StResp;
        end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
          // wdog_q counts completed ACTIVE cycles, so this edge ends cycle TIMEOUT.
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Registered so ready is low throughout reset and rises on the first edge after release.
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wdog_q      <= '0;
      req_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      req_ready_q <= req_ready_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = (state_q == StResp);
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_err     = err_q;
  assign bus.resp_timeout = tmo_q;
  assign bus.wb_addr      = addr_q;
  assign bus.wb_wdata     = wdata_q;
  assign bus.wb_sel       = sel_q;
  assign bus.wb_we        = we_q;
  assign bus.wb_cyc       = cyc_q;
  assign bus.wb_stb       = cyc_q;

endmodule
